bsg_fma_div_iter: RTL and testbench



---
 rtl/bsg_fma_div_iter.sv | 124 ++++++++++++
 tb/tb_bsg_fma_div_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fma_div_iter.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, valid/ready in, valid/yumi out.
// Results are presented only from dedicated output registers loaded on the final iteration.
module bsg_fma_div_iter #(
    parameter int exp_p = 8,
    parameter int sig_p = 23,
    localparam int width_lp = exp_p + sig_p + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    output logic                ready_o,
    input  logic [width_lp-1:0] dividend_i,
    input  logic [width_lp-1:0] divisor_i,
    output logic                v_o,
    input  logic                yumi_i,
    output logic [width_lp-1:0] quotient_o,
    output logic [width_lp-1:0] remainder_o,
    output logic                div_by_zero_o
);

    localparam int cnt_w_lp = $clog2(width_lp);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_lp - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = {{(cnt_w_lp-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } state_e;

    state_e                state_r;
    logic                  ready_r;
    logic                  v_r;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic [width_lp-1:0]   dvd_r;
    logic [width_lp-1:0]   dsr_r;
    logic [width_lp-1:0]   rem_r;
    logic [width_lp-1:0]   quot_r;
    logic [width_lp-1:0]   quot_out_r;
    logic [width_lp-1:0]   rem_out_r;
    logic                  dbz_r;

    logic [width_lp:0]     trial_s;
    logic                  qbit_s;
    logic [width_lp-1:0]   rem_next_s;
    logic [width_lp-1:0]   quot_next_s;

    // One restoring-division step. When the trial fits, the difference is below the
    // divisor, so subtracting in the low width_lp bits alone is exact.
    always_comb begin
        trial_s     = {rem_r, dvd_r[width_lp-1]};
        qbit_s      = (trial_s >= {1'b0, dsr_r});
        quot_next_s = {quot_r[width_lp-2:0], qbit_s};
        if (qbit_s) begin
            rem_next_s = trial_s[width_lp-1:0] - dsr_r;
        end else begin
            rem_next_s = trial_s[width_lp-1:0];
        end
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= st_idle;
            ready_r    <= 1'b1;
            v_r        <= 1'b0;
            cnt_r      <= {cnt_w_lp{1'b0}};
            dvd_r      <= {width_lp{1'b0}};
            dsr_r      <= {width_lp{1'b0}};
            rem_r      <= {width_lp{1'b0}};
            quot_r     <= {width_lp{1'b0}};
            quot_out_r <= {width_lp{1'b0}};
            rem_out_r  <= {width_lp{1'b0}};
            dbz_r      <= 1'b0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (v_i) begin
                        dvd_r   <= dividend_i;
                        dsr_r   <= divisor_i;
                        rem_r   <= {width_lp{1'b0}};
                        quot_r  <= {width_lp{1'b0}};
                        cnt_r   <= {cnt_w_lp{1'b0}};
                        ready_r <= 1'b0;
                        state_r <= st_calc;
                    end
                end
                st_calc: begin
                    dvd_r  <= {dvd_r[width_lp-2:0], 1'b0};
                    rem_r  <= rem_next_s;
                    quot_r <= quot_next_s;
                    cnt_r  <= cnt_r + cnt_one_lp;
                    if (cnt_r == last_cnt_lp) begin
                        quot_out_r <= quot_next_s;
                        rem_out_r  <= rem_next_s;
                        dbz_r      <= (dsr_r == {width_lp{1'b0}});
                        v_r        <= 1'b1;
                        state_r    <= st_done;
                    end
                end
                st_done: begin
                    // yumi_i is only honoured here; elsewhere it is ignored.
                    if (yumi_i) begin
                        v_r     <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= st_idle;
                    end
                end
                default: begin
                    v_r     <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= st_idle;
                end
            endcase
        end
    end

    assign ready_o       = ready_r;
    assign v_o           = v_r;
    assign quotient_o    = quot_out_r;
    assign remainder_o   = rem_out_r;
    assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_bsg_fma_div_iter.sv
// Self-checking bench for bsg_fma_div_iter: directed and random divisions with a scoreboard
// of expected results built from the language's own / and % operators.
module tb_bsg_fma_div_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  dividend_i;
    logic [W-1:0]  divisor_i;
    logic          v_o;
    logic          yumi_i;
    logic [W-1:0]  quotient_o;
    logic [W-1:0]  remainder_o;
    logic          div_by_zero_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    bsg_fma_div_iter #(.exp_p(8), .sig_p(23)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .v_o           (v_o),
        .yumi_i        (yumi_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dbz = (b == 32'd0);
        e.q   = e.dbz ? 32'hFFFF_FFFF : a / b;
        e.r   = e.dbz ? a : a % b;
        sb_q.push_back(e);
    endtask

    // One full transaction; poke drives v_i with junk in CALC (and in DONE when hold>0).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("ready_before_op", ready_o, 1'b1);
        dividend_i = a;
        divisor_i  = b;
        v_i        = 1'b1;
        push_expected(a, b);
        @(negedge clk);
        v_i        = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        chk1("ready_low_calc", ready_o, 1'b0);
        chk1("v_low_calc", v_o, 1'b0);
        n = 0;
        if (poke) begin
            v_i = 1'b1;
            @(negedge clk);
            v_i = 1'b0;
            n = 1;
        end
        // n counts rising edges after the accepting edge until v_o is seen.
        while (!v_o && n < 2 * W) begin
            @(negedge clk);
            n++;
        end
        chk("latency_edges", n, W);
        chk("sb_size", sb_q.size(), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i <= hold; i++) begin
                chk("quotient", quotient_o, e.q);
                chk("remainder", remainder_o, e.r);
                chk1("div_by_zero", div_by_zero_o, e.dbz);
                chk1("v_held", v_o, 1'b1);
                chk1("ready_low_done", ready_o, 1'b0);
                if (i < hold) begin
                    if (poke && i == 0) begin
                        v_i = 1'b1;
                    end
                    @(negedge clk);
                    v_i = 1'b0;
                end
            end
            if (b != 32'd0) begin
                chk("invariant", quotient_o * b + remainder_o, a);
                chk1("rem_lt_divisor", remainder_o < b, 1'b1);
            end
        end
        chk1("yumi_legal", v_o, 1'b1);
        if (v_o) begin
            yumi_i = 1'b1;
            @(negedge clk);
            yumi_i = 1'b0;
            chk1("v_after_yumi", v_o, 1'b0);
            chk1("ready_after_yumi", ready_o, 1'b1);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;
        reset_i    = 1'b1;
        v_i        = 1'b0;
        yumi_i     = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        repeat (2) @(negedge clk);
        chk1("reset_ready", ready_o, 1'b1);
        chk1("reset_v", v_o, 1'b0);
        chk("reset_quotient", quotient_o, 32'd0);
        chk("reset_remainder", remainder_o, 32'd0);
        chk1("reset_dbz", div_by_zero_o, 1'b0);
        reset_i = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op(32'd3, 32'd10, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'd5, 32'd0, 0, 1'b0);
        run_op(32'd12345, 32'd67, 10, 1'b1);

        // Reset on CALC cycle 5 discards the operation.
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        v_i        = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        repeat (4) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk1("midreset_v", v_o, 1'b0);
        chk1("midreset_ready", ready_o, 1'b1);
        chk("midreset_quotient", quotient_o, 32'd0);
        chk("midreset_remainder", remainder_o, 32'd0);
        run_op(32'd1000, 32'd3, 0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            run_op(a, b, i % 4, (i % 5 == 0));
        end

        // Divisors that are multiplier products, some dividends exact multiples.
        for (int i = 0; i < 40; i++) begin
            b = 32'($urandom_range(1, 65535)) * 32'($urandom_range(1, 65535));
            a = (i % 2 == 0) ? b * 32'($urandom_range(1, 7)) : $urandom;
            run_op(a, b, 0, 1'b0);
        end

        chk("sb_empty_at_end", sb_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        chk1("no_spurious_v", v_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
